xor32_stream_descrambler: RTL and testbench
===========================================

Name: xor32_stream_descrambler

Overview:
- Receive side of the ALU32 XOR keystream path: each accepted 32-bit scrambled word is XORed with a 32-bit LFSR keystream, recovering the plaintext word.
- Keystream is a Fibonacci LFSR advanced STEPS single-bit shifts per word, one shift per clock, so the block is multi-cycle.
- Sits between a valid/ready word source and a valid/ready sink in the datapath.

Parameters:
- POLY, 32'h04C11DB7, LFSR feedback tap mask.
- SEED, 32'hFFFFFFFF, keystream value after reset; also the substitute for an all-zero seed.
- STEPS, 4, LFSR shifts per word; legal range 1..32.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- SeedLoad  in  1  load a new keystream seed.
- SeedIn  in  32  seed value.
- InValid  in  1  input word valid.
- InReady  out  1  block can accept an input word.
- InData  in  32  scrambled word.
- OutValid  out  1  output word valid.
- OutReady  in  1  sink accepts the output word.
- OutData  out  32  descrambled word.
- Busy  out  1  high while the LFSR is advancing (state ADV).

Behaviour:
- Reset (Rst=1 at an edge): Key=SEED, state=IDLE, OutValid=0, OutData=0, Busy=0, step counter=0. Reset overrides every other input, including mid-advance.
- States: IDLE, ADV.
- Key step: Key <= {Key[30:0], ^(Key & POLY)}.
- InReady = (state==IDLE) && !SeedLoad && (!OutValid || OutReady). This is combinational.
- Accept occurs when InValid && InReady at an edge. On accept:
  - OutData <= InData ^ Key (current, un-advanced Key).
  - OutValid <= 1.
  - Counter <= STEPS-1.
  - State -> ADV.
- Latency: OutValid rises on the edge that accepts the word; the word is visible in the following cycle.
- ADV:
  - Key steps once per cycle.
  - Counter decrements each cycle; when counter==0, the final step happens and state -> IDLE.
  - Duration is STEPS cycles.
  - Input throughput is at most one word per STEPS+1 cycles.
- Output handshake:
  - OutValid && OutReady at an edge clears OutValid, unless a new word is accepted on that same edge; then OutValid stays 1 with the new OutData.
  - OutData is held stable while OutValid=1 and OutReady=0.
  - A stalled output does not stall ADV. It blocks only the next accept.
- SeedLoad at an edge (not in reset):
  - Key <= (SeedIn==0) ? SEED : SeedIn. An all-zero LFSR is never loaded.
  - State -> IDLE; any in-progress advance is aborted and the counter is cleared.
  - OutValid and OutData are unaffected.
  - No input is accepted on that edge, since InReady is forced low.
- InData is ignored when not accepted. InValid may drop without a transfer; no protocol error is flagged.
- Encoder pairing: a scrambler with the same POLY, SEED, and STEPS, fed the same word sequence, yields identity through this block.

Optional Feature:
- Macro: XOR32_DESCR_WORDCNT_EN.
- Defined:
  - Adds output port WordCount (out, 32): the number of words accepted since reset or the last SeedLoad.
  - Increments on each accept and wraps from 32'hFFFFFFFF to 0.
  - Reset value 0; SeedLoad clears it to 0.
  - If SeedLoad coincides with an accept-eligible cycle, no accept happens, so WordCount ends at 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with STEPS=1, then InData=0x12345678 with InValid=1, OutReady=1 -> OutData=0xEDCBA987, OutValid high the next cycle; Busy high for 1 cycle.
- STEPS=1, continuing: second word 0x00000000 -> OutData=0xFFFFFFFE, since one LFSR step from 0xFFFFFFFF gives feedback parity 0.
- STEPS=4, InValid held high -> words accepted exactly every 5 cycles; InReady low during the 4 ADV cycles.
- OutReady=0 after the first word -> OutData held stable; InReady stays low after ADV ends. Raising OutReady -> next word accepted on that same edge and OutValid stays 1.
- SeedLoad=1, SeedIn=0 during ADV with STEPS=4 -> state IDLE next cycle, Key=0xFFFFFFFF; next word 0xFFFFFFFF -> OutData=0x00000000. Repeat with SeedIn=0xA5A5A5A5 and word 0 -> OutData=0xA5A5A5A5.
- Rst asserted mid-ADV with OutValid=1 -> OutValid=0, Busy=0, InReady=1 the next cycle (provided SeedLoad=0). With XOR32_DESCR_WORDCNT_EN defined, WordCount=0; after 3 accepts WordCount=3.

Source files
------------

// File: rtl/xor32_stream_descrambler.sv
// rtl/xor32_stream_descrambler.sv - 32-bit LFSR keystream XOR descrambler, valid/ready in and out
// Optional word counter output: define XOR32_DESCR_WORDCNT_EN.
module xor32_stream_descrambler #(
   parameter logic [31:0] POLY  = 32'h04C11DB7,
   parameter logic [31:0] SEED  = 32'hFFFFFFFF,
   parameter int unsigned STEPS = 4
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        SeedLoad,
   input  logic [31:0] SeedIn,
   input  logic        InValid,
   output logic        InReady,
   input  logic [31:0] InData,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [31:0] OutData,
   output logic        Busy
`ifdef XOR32_DESCR_WORDCNT_EN
   ,
   output logic [31:0] WordCount
`endif
);

   typedef enum logic {
      IDLE = 1'b0,
      ADV  = 1'b1
   } state_t;

   localparam logic [4:0] CNT_LOAD = 5'(STEPS - 1);

   state_t      state_q, state_d;
   logic [31:0] key_q, key_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_data_q, out_data_d;
   logic [31:0] key_step;
   logic        in_ready;
   logic        accept;

   assign key_step = {key_q[30:0], ^(key_q & POLY)};
   assign in_ready = (state_q == IDLE) && !SeedLoad && (!out_valid_q || OutReady);
   assign accept   = InValid && in_ready;

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (out_valid_q && OutReady) begin
         out_valid_d = 1'b0;
      end
      // Accept uses the un-advanced key; a same-edge drain is overridden here.
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = InData ^ key_q;
      end

      if (SeedLoad) begin
         key_d   = (SeedIn == 32'h0) ? SEED : SeedIn;
         state_d = IDLE;
         cnt_d   = 5'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  cnt_d   = CNT_LOAD;
                  state_d = ADV;
               end
            end
            ADV: begin
               key_d = key_step;
               if (cnt_q == 5'd0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         key_q       <= SEED;
         cnt_q       <= 5'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'h0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

`ifdef XOR32_DESCR_WORDCNT_EN
   logic [31:0] word_cnt_q, word_cnt_d;

   always_comb begin
      word_cnt_d = word_cnt_q;
      if (SeedLoad) begin
         word_cnt_d = 32'h0;
      end else if (accept) begin
         word_cnt_d = word_cnt_q + 32'h1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         word_cnt_q <= 32'h0;
      end else begin
         word_cnt_q <= word_cnt_d;
      end
   end

   assign WordCount = word_cnt_q;
`endif

   assign InReady  = in_ready;
   assign OutValid = out_valid_q;
   assign OutData  = out_data_q;
   assign Busy     = (state_q == ADV);

endmodule

// File: tb/tb_xor32_stream_descrambler.sv
// tb/tb_xor32_stream_descrambler.sv - randomized model-checked bench for STEPS=1 and STEPS=4 instances
module tb_xor32_stream_descrambler;

   localparam logic [31:0] POLY = 32'h04C11DB7;
   localparam logic [31:0] SEED = 32'hFFFFFFFF;

   logic        clk = 1'b0;
   logic        rst, seed_load, in_valid, out_ready;
   logic [31:0] seed_in, in_data;
   logic        rdy [2];
   logic        ov  [2];
   logic        bsy [2];
   logic [31:0] od  [2];
   logic [31:0] wc  [2];

   int n_cmp = 0;
   int n_err = 0;

   // Reference: per instance, key at word start, ADV cycles left, output register, word count.
   int unsigned steps_of [2] = '{1, 4};
   logic [31:0] m_key  [2];
   int          m_busy [2];
   logic        m_ov   [2];
   logic [31:0] m_od   [2];
   logic [31:0] m_wc   [2];

   always #5 clk = ~clk;

   xor32_stream_descrambler #(.POLY(POLY), .SEED(SEED), .STEPS(1)) u_dut1 (
      .Clk(clk), .Rst(rst), .SeedLoad(seed_load), .SeedIn(seed_in),
      .InValid(in_valid), .InReady(rdy[0]), .InData(in_data),
      .OutValid(ov[0]), .OutReady(out_ready), .OutData(od[0]), .Busy(bsy[0])
`ifdef XOR32_DESCR_WORDCNT_EN
      , .WordCount(wc[0])
`endif
   );

   xor32_stream_descrambler #(.POLY(POLY), .SEED(SEED), .STEPS(4)) u_dut4 (
      .Clk(clk), .Rst(rst), .SeedLoad(seed_load), .SeedIn(seed_in),
      .InValid(in_valid), .InReady(rdy[1]), .InData(in_data),
      .OutValid(ov[1]), .OutReady(out_ready), .OutData(od[1]), .Busy(bsy[1])
`ifdef XOR32_DESCR_WORDCNT_EN
      , .WordCount(wc[1])
`endif
   );

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lfsr_next(input logic [31:0] k);
      logic fb;
      fb = ($countones(k & POLY) % 2) == 1;
      return {k[30:0], fb};
   endfunction

   function automatic logic model_ready(input int i);
      return (m_busy[i] == 0) && !seed_load && (!m_ov[i] || out_ready);
   endfunction

   // Drive inputs away from the edge, then compare every output against the model.
   task automatic drive(input logic r, input logic sl, input logic [31:0] si,
                        input logic iv, input logic [31:0] id, input logic ordy);
      @(negedge clk);
      rst = r; seed_load = sl; seed_in = si;
      in_valid = iv; in_data = id; out_ready = ordy;
      #1;
      for (int i = 0; i < 2; i++) begin
         check32($sformatf("inready%0d", i), 32'(rdy[i]), 32'(model_ready(i)));
         check32($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_busy[i] != 0));
         check32($sformatf("outvalid%0d", i), 32'(ov[i]), 32'(m_ov[i]));
         check32($sformatf("outdata%0d", i), od[i], m_od[i]);
`ifdef XOR32_DESCR_WORDCNT_EN
         check32($sformatf("wordcount%0d", i), wc[i], m_wc[i]);
`endif
      end
   endtask

   task automatic tick();
      logic acc;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_key[i] = SEED; m_busy[i] = 0; m_ov[i] = 1'b0; m_od[i] = 32'h0; m_wc[i] = 32'h0;
         end else begin
            acc = in_valid && model_ready(i);
            if (m_ov[i] && out_ready) m_ov[i] = 1'b0;
            if (acc) begin
               m_od[i] = in_data ^ m_key[i];
               m_ov[i] = 1'b1;
               m_wc[i] = m_wc[i] + 32'h1;
            end
            if (seed_load) begin
               m_key[i]  = (seed_in == 32'h0) ? SEED : seed_in;
               m_busy[i] = 0;
               m_wc[i]   = 32'h0;
            end else if (m_busy[i] > 0) begin
               m_key[i]  = lfsr_next(m_key[i]);
               m_busy[i] = m_busy[i] - 1;
            end else if (acc) begin
               m_busy[i] = int'(steps_of[i]);
            end
         end
      end
   endtask

   task automatic cyc(input logic r, input logic sl, input logic [31:0] si,
                      input logic iv, input logic [31:0] id, input logic ordy);
      drive(r, sl, si, iv, id, ordy);
      tick();
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
   endtask

   int last_acc;
   int n_acc;
   logic [31:0] held;

   initial begin
      rst = 1'b1; seed_load = 1'b0; seed_in = 32'h0;
      in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         m_key[i] = SEED; m_busy[i] = 0; m_ov[i] = 1'b0; m_od[i] = 32'h0; m_wc[i] = 32'h0;
      end
      do_reset();

      // Reset state and first words with STEPS=1
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h12345678, 1'b1);
      check32("reset_outvalid", 32'(ov[0]), 32'h0);
      check32("reset_inready", 32'(rdy[0]), 32'h1);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      check32("first_word", od[0], 32'hEDCBA987);
      check32("first_busy", 32'(bsy[0]), 32'h1);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
      check32("busy_one_cycle", 32'(bsy[0]), 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      check32("second_word", od[0], 32'hFFFFFFFE);
      tick();

      // STEPS=4 throughput with InValid held high
      do_reset();
      last_acc = -1;
      n_acc = 0;
      for (int c = 0; c < 21; c++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom, 1'b1);
         if (rdy[1]) begin
            if (last_acc >= 0) check32("accept_spacing", 32'(c - last_acc), 32'd5);
            last_acc = c;
            n_acc++;
         end
         tick();
      end
      check32("accept_count", 32'(n_acc), 32'd5);

      // Output stall on STEPS=4
      do_reset();
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);
      held = m_od[1];
      for (int c = 0; c < 6; c++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1, $urandom, 1'b0);
         check32("stall_hold", od[1], held);
         check32("stall_notready", 32'(rdy[1]), 32'h0);
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0BADBEEF, 1'b1);
      check32("unstall_ready", 32'(rdy[1]), 32'h1);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      check32("unstall_valid", 32'(ov[1]), 32'h1);
      tick();

      // SeedLoad mid-advance, zero and non-zero seeds
      do_reset();
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h11111111, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b1);
      check32("seed0_idle", 32'(bsy[1]), 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      check32("seed0_word", od[1], 32'h00000000);
      tick();
      cyc(1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 32'h0, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      check32("seedA5_word", od[1], 32'hA5A5A5A5);
      tick();

      // Reset mid-advance with output pending
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h5555AAAA, 1'b0);
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check32("rst_outvalid", 32'(ov[1]), 32'h0);
      check32("rst_busy", 32'(bsy[1]), 32'h0);
      check32("rst_inready", 32'(rdy[1]), 32'h1);
      tick();

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
             ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom),
             ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
             32'($urandom),
             ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
